// File: rtl/stack_ctl.sv
// stack_ctl: operand-stack controller for the writeback stage.
// TOS lives in a register; deeper entries are spilled to / refilled from a single-port sync RAM.
module stack_ctl #(
    parameter int         DEPTH      = 1024,
    parameter int         AW         = 10,
    parameter logic [1:0] UC_PUSHALU = 2'b01,
    parameter logic [1:0] UC_PUSHIMM = 2'b10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_4a,
    output logic          req_ready_4a,
    input  logic [1:0]    c__to_push_4a,
    input  logic [10:0]   st__to_pop_4a,
    input  logic [34:0]   st__to_push_4a,
    output logic [34:0]   tos_out,
    output logic          tos_valid,
    output logic [AW:0]   sp,
    output logic          fault,
    output logic [1:0]    fault_code,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [34:0]   ram_wdata,
    input  logic [34:0]   ram_rdata
);

    localparam int W = (AW + 1 > 11) ? AW + 1 : 11;
    localparam logic [W-1:0] DEPTH_W = W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_REFILL = 2'b01,
        ST_FAULT  = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [AW:0]   sp_q, sp_d;
    logic [34:0]   tos_q, tos_d;
    logic          tos_valid_q, tos_valid_d;
    logic          fault_q, fault_d;
    logic [1:0]    fault_code_q, fault_code_d;

    logic          accept_s;
    logic          push_s;
    logic [W-1:0]  n_w_s;
    logic [W-1:0]  sp_w_s;
    logic [W-1:0]  rem_w_s;
    logic          under_s;
    logic          over_s;

    assign push_s   = (c__to_push_4a == UC_PUSHALU) || (c__to_push_4a == UC_PUSHIMM);
    assign accept_s = req_valid_4a && (state_q == ST_RUN) && !rst;
    assign n_w_s    = W'(st__to_pop_4a);
    assign sp_w_s   = W'(sp_q);
    assign rem_w_s  = sp_w_s - n_w_s;
    assign under_s  = n_w_s > sp_w_s;
    // rem_w_s may wrap on underflow, but underflow takes priority over this check
    assign over_s   = (rem_w_s + {{(W-1){1'b0}}, push_s}) > DEPTH_W;

    // Next-state, fault and RAM-port decode for the accepted request
    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        tos_d        = tos_q;
        tos_valid_d  = tos_valid_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        ram_we       = 1'b0;
        ram_addr     = {AW{1'b0}};
        ram_wdata    = 35'd0;
        case (state_q)
            ST_RUN: begin
                if (accept_s) begin
                    if (under_s) begin
                        fault_d      = 1'b1;
                        fault_code_d = 2'b01;
                        state_d      = ST_FAULT;
                    end else if (over_s) begin
                        fault_d      = 1'b1;
                        fault_code_d = 2'b10;
                        state_d      = ST_FAULT;
                    end else if (push_s) begin
                        tos_d       = st__to_push_4a;
                        tos_valid_d = 1'b1;
                        sp_d        = rem_w_s[AW:0] + {{AW{1'b0}}, 1'b1};
                        if ((n_w_s == {W{1'b0}}) && (sp_q != {(AW+1){1'b0}})) begin
                            ram_we    = 1'b1;
                            ram_addr  = sp_q[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
                            ram_wdata = tos_q;
                        end else begin
                            ram_we = 1'b0;
                        end
                    end else if (n_w_s != {W{1'b0}}) begin
                        sp_d        = rem_w_s[AW:0];
                        tos_valid_d = 1'b0;
                        if (rem_w_s != {W{1'b0}}) begin
                            ram_addr = rem_w_s[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
                            state_d  = ST_REFILL;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_REFILL: begin
                tos_d       = ram_rdata;
                tos_valid_d = 1'b1;
                state_d     = ST_RUN;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            sp_q         <= {(AW+1){1'b0}};
            tos_q        <= 35'd0;
            tos_valid_q  <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            tos_q        <= tos_d;
            tos_valid_q  <= tos_valid_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign req_ready_4a = (state_q == ST_RUN);
    assign tos_out      = tos_q;
    assign tos_valid    = tos_valid_q;
    assign sp           = sp_q;
    assign fault        = fault_q;
    assign fault_code   = fault_code_q;

endmodule
